// File: rtl/qnt_pipe.sv
// qnt_pipe: JPEG quantiser placed after the FDCT.
//
// Takes signed DCT coefficients, 64 per block in raster order. Each one is
// divided by its quantisation table entry using a reciprocal multiply.
// Rounding is half away from zero. The result is saturated to a symmetric
// DOUT_W-bit range. Luma or chroma tables are chosen once per block.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   din        : signed coefficient, DIN_W bits
//   din_valid  : din is valid
//   din_ready  : din is accepted this cycle (combinational from the output stage)
//   tbl_sel    : 0 = luma, 1 = chroma; sampled on the coefficient at index 0
//   dout       : signed quantised coefficient, DOUT_W bits
//   dout_valid : dout is valid
//   dout_ready : downstream accepts dout
//   dout_first : dout is coefficient 0 (DC) of a block
//   dout_last  : dout is coefficient 63 of a block
//   blk_cnt    : completed output blocks, wraps at 2^16
module qnt_pipe #(
    parameter int DIN_W   = 12,
    parameter int DOUT_W  = 8,
    parameter int RECIP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DIN_W-1:0]  din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     tbl_sel,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_first,
    output logic                     dout_last,
    output logic [15:0]              blk_cnt
);

    localparam int PROD_W  = DIN_W + RECIP_W;
    localparam int MAG_MAX = 2 ** (DOUT_W - 1) - 1;

    typedef int unsigned q_tbl_t [64];

    // Standard JPEG luminance table (quality 50), raster order.
    localparam q_tbl_t Q_LUMA = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };

    // Standard JPEG chrominance table, raster order.
    localparam q_tbl_t Q_CHROMA = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    // R(Q) = floor((2^RECIP_W + Q/2) / Q). Every table entry is >= 10, so R fits in RECIP_W bits.
    function automatic logic [RECIP_W-1:0] recip(input int unsigned q);
        logic [63:0] num;
        num = (64'd1 << RECIP_W) + 64'(q / 2);
        return RECIP_W'(num / 64'(q));
    endfunction

    // Reciprocal ROMs, evaluated at elaboration.
    logic [RECIP_W-1:0] w_rom [2][64];

    for (genvar g = 0; g < 64; g++) begin : g_rom
        assign w_rom[0][g] = recip(Q_LUMA[g]);
        assign w_rom[1][g] = recip(Q_CHROMA[g]);
    end

    // Input index / table select
    logic [5:0] r_idx;
    logic       r_tbl;

    // Stage 1
    logic               r_s1_valid;
    logic [DIN_W-1:0]   r_s1_mag;
    logic               r_s1_neg;
    logic               r_s1_first;
    logic               r_s1_last;
    logic [RECIP_W-1:0] r_s1_recip;

    // Stage 2
    logic              r_s2_valid;
    logic [PROD_W-1:0] r_s2_prod;
    logic              r_s2_neg;
    logic              r_s2_first;
    logic              r_s2_last;

    // Stage 3 (output)
    logic signed [DOUT_W-1:0] r_dout;
    logic                     r_dout_valid;
    logic                     r_dout_first;
    logic                     r_dout_last;
    logic [15:0]              r_blk_cnt;

    logic                     w_en;
    logic                     w_in_xfer;
    logic                     w_tbl;
    logic [RECIP_W-1:0]       w_recip;
    logic [DIN_W-1:0]         w_mag;
    logic [PROD_W:0]          w_round;
    logic [DIN_W:0]           w_m;
    logic [DOUT_W-1:0]        w_sat;
    logic signed [DOUT_W-1:0] w_q;

    always_comb begin
        w_en      = ~r_dout_valid | dout_ready;
        w_in_xfer = din_valid & w_en;

        // At index 0 the table comes straight from tbl_sel so the DC term
        // already uses the table being latched for this block.
        w_tbl   = (r_idx == 6'd0) ? tbl_sel : r_tbl;
        w_recip = w_rom[w_tbl][r_idx];

        // Two's-complement negation in DIN_W bits, read as unsigned, is exact
        // even for -2^(DIN_W-1): its bit pattern is 2^(DIN_W-1).
        w_mag = din[DIN_W-1] ? DIN_W'(-din) : DIN_W'(din);

        // Round half up on the magnitude = half away from zero once the sign is reapplied.
        w_round = {1'b0, r_s2_prod} + (PROD_W + 1)'(64'd1 << (RECIP_W - 1));
        w_m     = w_round[PROD_W:RECIP_W];
        w_sat   = (w_m > (DIN_W + 1)'(MAG_MAX)) ? DOUT_W'(MAG_MAX) : DOUT_W'(w_m);
        // A zero magnitude stays zero after negation, so -0 cannot appear.
        w_q     = r_s2_neg ? -$signed(w_sat) : $signed(w_sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_tbl        <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_mag     <= '0;
            r_s1_neg     <= 1'b0;
            r_s1_first   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_recip   <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_prod    <= '0;
            r_s2_neg     <= 1'b0;
            r_s2_first   <= 1'b0;
            r_s2_last    <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_first <= 1'b0;
            r_dout_last  <= 1'b0;
            r_blk_cnt    <= '0;
        end else begin
            if (w_in_xfer) begin
                r_idx <= r_idx + 6'd1;
                if (r_idx == 6'd0) begin
                    r_tbl <= tbl_sel;
                end
            end

            // The whole pipe moves together; a stalled output freezes every stage.
            if (w_en) begin
                r_s1_valid <= din_valid;
                r_s1_mag   <= w_mag;
                r_s1_neg   <= din[DIN_W-1];
                r_s1_first <= (r_idx == 6'd0);
                r_s1_last  <= (r_idx == 6'd63);
                r_s1_recip <= w_recip;

                r_s2_valid <= r_s1_valid;
                r_s2_prod  <= PROD_W'(r_s1_mag) * PROD_W'(r_s1_recip);
                r_s2_neg   <= r_s1_neg;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;

                r_dout_valid <= r_s2_valid;
                r_dout       <= w_q;
                r_dout_first <= r_s2_first;
                r_dout_last  <= r_s2_last;
            end

            if (r_dout_valid && dout_ready && r_dout_last) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
        end
    end

    assign din_ready  = w_en;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_first = r_dout_first;
    assign dout_last  = r_dout_last;
    assign blk_cnt    = r_blk_cnt;

endmodule
